// File: rtl/d_cache_2way_wb.sv
// 2-way set-associative write-back data cache, one word per line, sram-like bus.
// Define DCACHE_WRITE_ALLOCATE_EN to allocate on cached write misses (else write-around).
module d_cache_2way_wb #(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        no_cache,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS      = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, WB, RD, UW} state_e;

  state_e state_q, state_d;
  logic   addr_rcv_q, addr_rcv_d;
  logic   victim_q, victim_d;

  logic [1:0][SETS-1:0] valid_q, valid_d;
  logic [1:0][SETS-1:0] dirty_q, dirty_d;
  logic [SETS-1:0]      lru_q, lru_d;

  logic [TAG_WIDTH-1:0] tag_mem  [2][SETS];
  logic [31:0]          data_mem [2][SETS];

  logic [1:0]           we;
  logic [TAG_WIDTH-1:0] wr_tag;
  logic [31:0]          wr_data;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   tag;
  logic [31:0]            line_addr;
  logic [3:0]             mask;
  logic                   hit0, hit1, hit;
  logic                   victim_way, bus_req;

  function automatic logic [31:0] merge(input logic [31:0] base,
                                        input logic [31:0] wd,
                                        input logic [3:0]  m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = m[i] ? wd[8*i +: 8] : base[8*i +: 8];
    return r;
  endfunction

  assign idx       = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag       = cpu_data_addr[31 -: TAG_WIDTH];
  assign line_addr = {cpu_data_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};

  assign hit0 = valid_q[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1 = valid_q[1][idx] && (tag_mem[1][idx] == tag);
  assign hit  = cpu_data_req && !no_cache && (state_q == IDLE) && (hit0 || hit1);

  assign victim_way = !valid_q[0][idx] ? 1'b0 :
                      !valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign bus_req    = (state_q != IDLE) && !addr_rcv_q;

  always_comb begin
    unique case (1'b1)
      cpu_data_size == 2'd0: mask = 4'b0001 << cpu_data_addr[1:0];
      cpu_data_size == 2'd1: mask = cpu_data_addr[1] ? 4'b1100 : 4'b0011;
      default:               mask = 4'b1111;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_rcv_d = addr_rcv_q;
    victim_d   = victim_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    lru_d      = lru_q;
    we         = 2'b00;
    wr_tag     = tag;
    wr_data    = cache_data_rdata;

    cpu_data_rdata   = '0;
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cache_data_req   = bus_req;
    cache_data_wr    = 1'b0;
    cache_data_size  = cpu_data_size;
    cache_data_addr  = cpu_data_addr;
    cache_data_wdata = cpu_data_wdata;

    if (cache_data_data_ok)
      addr_rcv_d = 1'b0;
    else if (bus_req && cache_data_addr_ok)
      addr_rcv_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        cache_data_req = 1'b0;
        addr_rcv_d     = 1'b0;
        if (hit) begin
          cpu_data_addr_ok = 1'b1;
          cpu_data_data_ok = 1'b1;
          cpu_data_rdata   = data_mem[hit1][idx];
          lru_d[idx]       = !hit1;
          if (cpu_data_wr) begin
            we[hit1]          = 1'b1;
            wr_data           = merge(data_mem[hit1][idx], cpu_data_wdata, mask);
            dirty_d[hit1][idx] = 1'b1;
          end
        end else if (cpu_data_req) begin
          if (no_cache) begin
            state_d = cpu_data_wr ? UW : RD;
`ifdef DCACHE_WRITE_ALLOCATE_EN
          end else begin
`else
          end else if (cpu_data_wr) begin
            state_d = UW;
          end else begin
`endif
            victim_d = victim_way;
            state_d  = (valid_q[victim_way][idx] && dirty_q[victim_way][idx]) ? WB : RD;
          end
        end
      end
      WB: begin
        cache_data_wr    = 1'b1;
        cache_data_size  = 2'b10;
        cache_data_addr  = {tag_mem[victim_q][idx], idx, {OFFSET_WIDTH{1'b0}}};
        cache_data_wdata = data_mem[victim_q][idx];
        if (cache_data_data_ok) begin
          dirty_d[victim_q][idx] = 1'b0;
          state_d                = RD;
        end
      end
      RD: begin
        if (!no_cache) begin
          cache_data_addr = line_addr;
          cache_data_size = 2'b10;
        end
        cpu_data_addr_ok = bus_req && cache_data_addr_ok;
        cpu_data_data_ok = cache_data_data_ok;
        cpu_data_rdata   = cache_data_rdata;
        if (cache_data_data_ok) begin
          state_d = IDLE;
          if (!no_cache) begin
            we[victim_q]           = 1'b1;
            valid_d[victim_q][idx] = 1'b1;
            dirty_d[victim_q][idx] = 1'b0;
            lru_d[idx]             = !victim_q;
`ifdef DCACHE_WRITE_ALLOCATE_EN
            if (cpu_data_wr) begin
              wr_data                = merge(cache_data_rdata, cpu_data_wdata, mask);
              dirty_d[victim_q][idx] = 1'b1;
            end
`endif
          end
        end
      end
      UW: begin
        cache_data_wr    = 1'b1;
        cpu_data_addr_ok = bus_req && cache_data_addr_ok;
        cpu_data_data_ok = cache_data_data_ok;
        cpu_data_rdata   = cache_data_rdata;
        if (cache_data_data_ok)
          state_d = IDLE;
      end
    endcase

    // A transaction caught by reset is dropped without touching the bus or arrays.
    if (rst) begin
      cache_data_req   = 1'b0;
      cpu_data_addr_ok = 1'b0;
      cpu_data_data_ok = 1'b0;
      we               = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (we[w]) begin
        tag_mem[w][idx]  <= wr_tag;
        data_mem[w][idx] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_rcv_q <= 1'b0;
      victim_q   <= 1'b0;
      valid_q    <= '0;
      dirty_q    <= '0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_rcv_q <= addr_rcv_d;
      victim_q   <= victim_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      lru_q      <= lru_d;
    end
  end

endmodule

// File: tb/tb_d_cache_2way_wb.sv
// Bench for d_cache_2way_wb: directed table, reset-abort sequence, random
// traffic against an LRU-list cache model over a randomly stalling bus slave.
module tb_d_cache_2way_wb;

  logic        clk = 1'b0;
  logic        rst, no_cache;
  logic        cpu_data_req, cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
  logic        cpu_data_addr_ok, cpu_data_data_ok;
  logic        cache_data_req, cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr, cache_data_wdata, cache_data_rdata;
  logic        cache_data_addr_ok, cache_data_data_ok;

  always #5 clk = ~clk;

  d_cache_2way_wb #(.INDEX_WIDTH(7), .OFFSET_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .no_cache(no_cache),
    .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr),
    .cpu_data_size(cpu_data_size), .cpu_data_addr(cpu_data_addr),
    .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata),
    .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
    .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr),
    .cache_data_size(cache_data_size), .cache_data_addr(cache_data_addr),
    .cache_data_wdata(cache_data_wdata), .cache_data_rdata(cache_data_rdata),
    .cache_data_addr_ok(cache_data_addr_ok), .cache_data_data_ok(cache_data_data_ok)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic nc, wr; logic [1:0] sz; logic [31:0] a, wd;
    logic hit, chk; logic [31:0] rd; int n;
    logic [31:0] a0; logic w0; logic [1:0] s0; logic [31:0] d0, a1;
  } vec_t;

  int vec_cnt = 0;
  int err_cnt = 0;
  bus_t log_q[$];
  logic [31:0] mem [logic [29:0]];
  logic hold = 1'b0;

  function automatic bus_t mkb(logic [31:0] a, logic w, logic [1:0] s, logic [31:0] d);
    bus_t b; b.addr = a; b.wr = w; b.size = s; b.wdata = d; return b;
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h5A5A0000;
  endfunction

  function automatic logic [3:0] bmask(logic [1:0] sz, logic [1:0] off);
    logic [3:0] m = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      if (sz == 2'd0) m[b] = (b == int'(off));
      else if (sz == 2'd1) m[b] = ((b / 2) == int'(off[1]));
      else m[b] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] mrg(logic [31:0] base, logic [31:0] wd, logic [3:0] m);
    logic [31:0] r = base;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // sram-like slave: random addr/data latency, optional data_ok hold
  initial begin
    int   phase, cnt;
    bus_t cur;
    phase = 0; cnt = 0;
    cache_data_addr_ok = 1'b0; cache_data_data_ok = 1'b0; cache_data_rdata = '0;
    forever begin
      @(negedge clk);
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      if (rst) begin
        phase = 0; cnt = 0;
      end else if (phase == 0) begin
        if (cache_data_req) begin
          if (cnt == 0) begin
            cache_data_addr_ok = 1'b1;
            cur = mkb(cache_data_addr, cache_data_wr, cache_data_size, cache_data_wdata);
            log_q.push_back(cur);
            phase = 1;
            cnt = $urandom_range(0, 2);
          end else cnt--;
        end
      end else if (!hold) begin
        if (cnt > 0) cnt--;
        else begin
          cache_data_data_ok = 1'b1;
          if (cur.wr)
            mem[cur.addr[31:2]] = mrg(mem_rd(cur.addr), cur.wdata,
                                      bmask(cur.size, cur.addr[1:0]));
          else
            cache_data_rdata = mem_rd(cur.addr);
          phase = 0;
          cnt = $urandom_range(0, 2);
        end
      end
    end
  end

  task automatic access(input logic nc, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic hit, output logic [31:0] rd, output logic aok);
    int cyc; logic done, rs;
    @(posedge clk); #1;
    log_q.delete();
    no_cache = nc; cpu_data_wr = wr; cpu_data_size = sz;
    cpu_data_addr = a; cpu_data_wdata = wd; cpu_data_req = 1'b1;
    cyc = 0; done = 1'b0; rs = 1'b0; aok = 1'b0; hit = 1'b0; rd = '0;
    while (!done && cyc < 400) begin
      @(negedge clk); #2;
      if (cache_data_req) rs = 1'b1;
      if (cpu_data_addr_ok) aok = 1'b1;
      if (cpu_data_data_ok) begin
        done = 1'b1;
        rd = cpu_data_rdata;
        hit = (cyc == 0) && !rs;
      end
      cyc++;
    end
    if (!done) begin
      vec_cnt++; err_cnt++;
      $display("FAIL timeout addr %h: got no data_ok expected data_ok", a);
    end
    @(posedge clk); #1;
    cpu_data_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; cpu_data_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic vec_t mk(logic nc, logic wr, logic [1:0] sz, logic [31:0] a,
                              logic [31:0] wd, logic hit, logic chk, logic [31:0] rd,
                              int n, logic [31:0] a0, logic w0, logic [1:0] s0,
                              logic [31:0] d0, logic [31:0] a1);
    vec_t v;
    v.nc = nc; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd; v.hit = hit; v.chk = chk;
    v.rd = rd; v.n = n; v.a0 = a0; v.w0 = w0; v.s0 = s0; v.d0 = d0; v.a1 = a1;
    return v;
  endfunction

  // model state: per-set recency list of line addresses (MRU first)
  logic [31:0] rq [128][$];
  logic [31:0] arch [logic [29:0]];
  bit          dty  [logic [31:0]];

  function automatic logic [31:0] arch_rd(logic [31:0] a);
    if (arch.exists(a[31:2])) return arch[a[31:2]];
    return mem_rd(a);
  endfunction

  initial begin
    vec_t tbl[13];
    logic h, ao;
    logic [31:0] rd;
    int cyc;

    #200000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    logic h, ao;
    logic [31:0] rd;
    int cyc;

    rst = 1'b1; no_cache = 1'b0; cpu_data_req = 1'b0; cpu_data_wr = 1'b0;
    cpu_data_size = 2'd2; cpu_data_addr = '0; cpu_data_wdata = '0;
    mem[30'h40] = 32'h11111111;

    tbl[0]  = mk(0,0,2,32'h100,0,          0,1,32'h11111111, 1,32'h100,0,2,0,0);
    tbl[1]  = mk(0,0,2,32'h100,0,          1,1,32'h11111111, 0,0,0,0,0,0);
    tbl[2]  = mk(0,1,0,32'h101,32'h0000AB00,1,0,0,           0,0,0,0,0,0);
    tbl[3]  = mk(0,0,2,32'h100,0,          1,1,32'h1111AB11, 0,0,0,0,0,0);
    tbl[4]  = mk(1,0,0,32'h102,0,          0,1,32'h11111111, 1,32'h102,0,0,0,0);
    tbl[5]  = mk(0,0,2,32'h100,0,          1,1,32'h1111AB11, 0,0,0,0,0,0);
    tbl[6]  = mk(0,0,2,32'h300,0,          0,1,32'h5A5A0300, 1,32'h300,0,2,0,0);
    tbl[7]  = mk(0,0,2,32'h100,0,          1,1,32'h1111AB11, 0,0,0,0,0,0);
    tbl[8]  = mk(0,0,2,32'h500,0,          0,1,32'h5A5A0500, 1,32'h500,0,2,0,0);
    tbl[9]  = mk(0,0,2,32'h300,0,          0,1,32'h5A5A0300, 2,32'h100,1,2,32'h1111AB11,32'h300);
`ifdef DCACHE_WRITE_ALLOCATE_EN
    tbl[10] = mk(0,1,2,32'h700,32'hDEADBEEF,0,0,0,           1,32'h700,0,2,0,0);
    tbl[11] = mk(0,0,2,32'h700,0,          1,1,32'hDEADBEEF, 0,0,0,0,0,0);
`else
    tbl[10] = mk(0,1,2,32'h700,32'hDEADBEEF,0,0,0,           1,32'h700,1,2,32'hDEADBEEF,0);
    tbl[11] = mk(0,0,2,32'h700,0,          0,1,32'hDEADBEEF, 1,32'h700,0,2,0,0);
`endif
    tbl[12] = mk(0,0,2,32'h100,0,          0,1,32'h1111AB11, 1,32'h100,0,2,0,0);

    do_reset();
    @(negedge clk); #2;
    check("rst.cache_req", 32'(cache_data_req), 0);
    check("rst.addr_ok", 32'(cpu_data_addr_ok), 0);
    check("rst.data_ok", 32'(cpu_data_data_ok), 0);

    for (int i = 0; i < 13; i++) begin
      access(tbl[i].nc, tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].wd, h, rd, ao);
      check($sformatf("v%0d.hit", i), 32'(h), 32'(tbl[i].hit));
      check($sformatf("v%0d.addr_ok", i), 32'(ao), 1);
      if (tbl[i].chk) check($sformatf("v%0d.rdata", i), rd, tbl[i].rd);
      check($sformatf("v%0d.nbus", i), 32'(log_q.size()), 32'(tbl[i].n));
      if (tbl[i].n > 0 && log_q.size() > 0) begin
        check($sformatf("v%0d.bus0_addr", i), log_q[0].addr, tbl[i].a0);
        check($sformatf("v%0d.bus0_wr", i), 32'(log_q[0].wr), 32'(tbl[i].w0));
        check($sformatf("v%0d.bus0_size", i), 32'(log_q[0].size), 32'(tbl[i].s0));
        if (tbl[i].w0) check($sformatf("v%0d.bus0_wdata", i), log_q[0].wdata, tbl[i].d0);
      end
      if (tbl[i].n > 1 && log_q.size() > 1)
        check($sformatf("v%0d.bus1_addr", i), log_q[1].addr, tbl[i].a1);
    end

    // reset while a dirty writeback waits for data_ok
    do_reset();
    access(0, 0, 2, 32'h100, 0, h, rd, ao);
    access(0, 1, 0, 32'h101, 32'h0000CD00, h, rd, ao);
    check("r33.sb_hit", 32'(h), 1);
    access(0, 0, 2, 32'h300, 0, h, rd, ao);
    @(posedge clk); #1;
    hold = 1'b1; log_q.delete();
    no_cache = 1'b0; cpu_data_wr = 1'b0; cpu_data_size = 2'd2;
    cpu_data_addr = 32'h500; cpu_data_req = 1'b1;
    cyc = 0;
    while (log_q.size() == 0 && cyc < 100) begin
      @(negedge clk); #2;
      cyc++;
    end
    check("r33.wb_seen", 32'(log_q.size()), 1);
    if (log_q.size() > 0) begin
      check("r33.wb_addr", log_q[0].addr, 32'h100);
      check("r33.wb_wr", 32'(log_q[0].wr), 1);
      check("r33.wb_wdata", log_q[0].wdata, 32'h1111CD11);
    end
    repeat (2) @(negedge clk);
    #2 check("r33.held_data_ok", 32'(cpu_data_data_ok), 0);
    @(posedge clk); #1;
    rst = 1'b1; cpu_data_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; hold = 1'b0;
    @(negedge clk); #2;
    check("r33.req_after_rst", 32'(cache_data_req), 0);
    access(0, 0, 2, 32'h100, 0, h, rd, ao);
    check("r33.miss", 32'(h), 0);
    check("r33.nbus", 32'(log_q.size()), 1);
    if (log_q.size() > 0) check("r33.rd_addr", log_q[0].addr, 32'h100);
    check("r33.rdata", rd, 32'h1111AB11);

    // random traffic against the model
    do_reset();
    for (int s = 0; s < 128; s++) rq[s].delete();
    arch.delete(); dty.delete();
    for (int k = 0; k < 400; k++) begin
      logic nc, wr, hh, aa;
      logic [1:0] sz;
      logic [31:0] a, wd, la, erd, got, v;
      int s, p;
      bus_t exq[$];
      exq.delete();
      nc = ($urandom_range(0, 9) == 0);
      wr = $urandom_range(0, 1) == 1;
      sz = 2'($urandom_range(0, 2));
      wd = $urandom;
      if (nc) a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2);
      else a = (32'($urandom_range(0, 3)) << 9) | (32'(16 + $urandom_range(0, 1)) << 2);
      if (sz == 2'd0) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 2'd1) a[1] = ($urandom_range(0, 1) == 1);
      la = {a[31:2], 2'b00};
      erd = arch_rd(la);
      s = int'(a[8:2]);
      if (nc) begin
        exq.push_back(mkb(a, wr, sz, wd));
      end else begin
        p = -1;
        for (int j = 0; j < rq[s].size(); j++) if (rq[s][j] == la) p = j;
        if (p >= 0) begin
          rq[s].delete(p);
          rq[s].push_front(la);
          if (wr) dty[la] = 1'b1;
`ifdef DCACHE_WRITE_ALLOCATE_EN
        end else begin
`else
        end else if (wr) begin
          exq.push_back(mkb(a, 1'b1, sz, wd));
        end else begin
`endif
          if (rq[s].size() == 2) begin
            v = rq[s][1];
            rq[s].pop_back();
            if (dty.exists(v)) begin
              exq.push_back(mkb(v, 1'b1, 2'd2, arch_rd(v)));
              dty.delete(v);
            end
          end
          exq.push_back(mkb(la, 1'b0, 2'd2, 0));
          rq[s].push_front(la);
          if (wr) dty[la] = 1'b1;
        end
      end
      if (wr) arch[a[31:2]] = mrg(erd, wd, bmask(sz, a[1:0]));
      access(nc, wr, sz, a, wd, hh, got, aa);
      check($sformatf("rnd%0d.hit", k), 32'(hh), 32'(exq.size() == 0));
      check($sformatf("rnd%0d.addr_ok", k), 32'(aa), 1);
      if (!wr) check($sformatf("rnd%0d.rdata", k), got, erd);
      check($sformatf("rnd%0d.nbus", k), 32'(log_q.size()), 32'(exq.size()));
      for (int j = 0; j < exq.size() && j < log_q.size(); j++) begin
        check($sformatf("rnd%0d.bus%0d_addr", k, j), log_q[j].addr, exq[j].addr);
        check($sformatf("rnd%0d.bus%0d_wr", k, j), 32'(log_q[j].wr), 32'(exq[j].wr));
        check($sformatf("rnd%0d.bus%0d_size", k, j), 32'(log_q[j].size), 32'(exq[j].size));
        if (exq[j].wr)
          check($sformatf("rnd%0d.bus%0d_wdata", k, j), log_q[j].wdata, exq[j].wdata);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
